bus_responder: RTL



---
 rtl/bus_pkg.sv | 27 ++
 rtl/resp_regfile.sv | 34 +++
 rtl/bus_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus responder slice: bus widths, FSM and op encodings,
// and the filler word returned for reads that hit no register.
package bus_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [DATA_W-1:0] RD_ERR_VALUE = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } resp_state_t;

    typedef enum logic {
        BUS_WRITE = 1'b0,
        BUS_READ  = 1'b1
    } bus_op_t;

    // Full-width compare so high address bits can never alias onto a register.
    function automatic logic addr_below(input logic [ADDR_W-1:0] addr, input int limit);
        return int'(addr) < limit;
    endfunction

endpackage

// File: rtl/resp_regfile.sv
// DEPTH x DATA_W register array: synchronous write, combinational read, cleared on reset.
// Word 0 is brought out separately so it can feed the parallel output port.
module resp_regfile
    import bus_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] word0
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign word0 = mem[0];

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped slave on the shared cs/read/address/data/ready bus with programmable
// wait states, a read-only ID word, and register 0 mirrored on port_out.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | no access in flight, ready high
// ST_WAIT   | request latched, counting down wait states, ready low
// ST_ACCESS | single cycle: write committed / read data captured, ready low
// ST_DONE   | access complete, ready high, read data on the bus while cs held
module bus_responder
    import bus_pkg::*;
#(
    parameter int                DEPTH       = 8,
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] ID_ADDR     = 16'h00FF,
    parameter logic [DATA_W-1:0] ID_VALUE    = 16'hB5A1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    output logic              ready,
    output logic              err,
    output logic [DATA_W-1:0] port_out
);

    localparam int          IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WS_LOAD      = 4'(WAIT_STATES);
    localparam resp_state_t ST_AFTER_REQ = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;

    resp_state_t       state;
    bus_op_t           lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        wait_cnt;
    logic              cs_q;
    logic [DATA_W-1:0] rdata;

    logic              req;
    logic              lat_is_id;
    logic              lat_in_range;
    logic              commit_wr;
    logic              drive_en;
    logic [DATA_W-1:0] rf_rdata;

    // A held cs with a new {read, address} is a fresh request; it also aborts anything in flight.
    assign req = cs && (!cs_q || (read != lat_op) || (address != lat_addr));

    assign lat_is_id    = (lat_addr == ID_ADDR);
    assign lat_in_range = !lat_is_id && addr_below(lat_addr, DEPTH);

    assign commit_wr = (state == ST_ACCESS) && cs && !req
                       && (lat_op == BUS_WRITE) && lat_in_range;

    resp_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit_wr),
        .waddr (lat_addr[IDX_W-1:0]),
        .wdata (data),
        .raddr (lat_addr[IDX_W-1:0]),
        .rdata (rf_rdata),
        .word0 (port_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lat_op   <= BUS_WRITE;
            lat_addr <= '0;
            wait_cnt <= '0;
            cs_q     <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b1;
            err      <= 1'b0;
        end else begin
            cs_q <= cs;
            err  <= 1'b0;
            if (req) begin
                lat_op   <= bus_op_t'(read);
                lat_addr <= address;
                wait_cnt <= WS_LOAD;
                ready    <= 1'b0;
                state    <= ST_AFTER_REQ;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ready <= 1'b1;
                    end
                    ST_WAIT: begin
                        if (!cs) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                            if (wait_cnt == 4'd1) begin
                                state <= ST_ACCESS;
                            end
                        end
                    end
                    ST_ACCESS: begin
                        if (!cs) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            ready <= 1'b1;
                            if (lat_op == BUS_READ) begin
                                rdata <= lat_is_id    ? ID_VALUE :
                                         lat_in_range ? rf_rdata : RD_ERR_VALUE;
                                err   <= !(lat_in_range || lat_is_id);
                            end else begin
                                // ID word is read-only, so a write there is flagged like a miss.
                                err   <= !lat_in_range;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!cs) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Current read is also required so a read-to-write turnaround never fights the initiator.
    assign drive_en = (state == ST_DONE) && (lat_op == BUS_READ) && cs && read;
    assign data     = drive_en ? rdata : 'z;

endmodule
